// File: rtl/sequence_detector_0110_if.sv
// sequence_detector_0110_if: serial bit stream in (en, data_in) and detection flag out (detected)
interface sequence_detector_0110_if;
  logic en;
  logic data_in;
  logic detected;
  modport master (output en, output data_in, input detected);
  modport slave (input en, input data_in, output detected);
endinterface

// File: rtl/sequence_detector_0110.sv
// sequence_detector_0110: Moore non-overlapping 0110 detector; ports clk, reset (sync, active-high), bus.slave (en, data_in in; detected out)
module sequence_detector_0110 (
  input logic clk,
  input logic reset,
  sequence_detector_0110_if.slave bus
);
  localparam logic [2:0] IDLE  = 3'b000;
  localparam logic [2:0] S0    = 3'b001;
  localparam logic [2:0] S01   = 3'b010;
  localparam logic [2:0] S011  = 3'b011;
  localparam logic [2:0] S0110 = 3'b100;
  logic [2:0] state;
  logic [2:0] state_nx;
  always_comb begin
    state_nx = !bus.en         ? state :
               state == IDLE   ? (bus.data_in ? IDLE : S0) :
               state == S0     ? (bus.data_in ? S01  : S0) :
               state == S01    ? (bus.data_in ? S011 : S0) :
               state == S011   ? (bus.data_in ? IDLE : S0110) :
                                 IDLE;
  end
  always_ff @(posedge clk) begin
    state <= reset ? IDLE : state_nx;
  end
  assign bus.detected = (state == S0110);
endmodule

// File: tb/tb_sequence_detector_0110.sv
module tb_sequence_detector_0110;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int tests = 0;
  int fails = 0;
  logic exp_q[$];
  bit hist[$];
  bit m_det = 1'b0;
  sequence_detector_0110_if bus ();
  sequence_detector_0110 dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  task automatic model(input logic r, input logic e, input logic d);
    if (r) begin
      hist.delete();
      m_det = 1'b0;
    end else if (e) begin
      if (m_det) begin
        m_det = 1'b0;
        hist.delete();
      end else begin
        hist.push_back(d);
        if (hist.size() >= 4) begin
          int n = hist.size();
          if (hist[n-4] == 0 && hist[n-3] == 1 && hist[n-2] == 1 && hist[n-1] == 0) begin
            m_det = 1'b1;
            hist.delete();
          end
        end
      end
    end
  endtask
  task automatic step(input logic r, input logic e, input logic d);
    reset = r;
    bus.en = e;
    bus.data_in = d;
    @(posedge clk);
    #1;
    model(r, e, d);
    exp_q.push_back(m_det);
  endtask
  task automatic bits(input logic [15:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) step(1'b0, 1'b1, v[i]);
  endtask
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      logic e;
      e = exp_q.pop_front();
      tests++;
      if (bus.detected !== e) begin
        fails++;
        $display("FAIL detected at %0t: got %b expected %b", $time, bus.detected, e);
      end
    end
  end
  initial begin
    bus.en = 1'b0;
    bus.data_in = 1'b0;
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b1);
    bits(16'b0110, 4);
    step(1'b0, 1'b1, 1'b0);
    bits(16'b0110, 4);
    bits(16'b0110110, 7);
    step(1'b0, 1'b1, 1'b1);
    bits(16'b01110110, 8);
    bits(16'b11, 2);
    bits(16'b000110, 6);
    bits(16'b11, 2);
    bits(16'b0111, 4);
    step(1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b1, 1'b1);
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b1);
    step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b1);
    bits(16'b011, 3);
    step(1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b1);
    bits(16'b0110, 4);
    step(1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 3000; i++) begin
      logic r, e, d;
      r = ($urandom_range(0, 99) == 0);
      e = ($urandom_range(0, 3) != 0);
      d = ($urandom_range(0, 2) != 0) ^ ($urandom_range(0, 1) == 0);
      step(r, e, d);
    end
    step(1'b0, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
  initial begin
    #500000;
    $display("FAIL timeout: bench did not finish, expected completion");
    $fatal(1, "timeout");
  end
endmodule
